// File: rtl/alu_seq_pkg.sv
// Shared types and ALU select codes for the multi-nibble ALU sequencer.
// Opcode 5 (CMP) becomes legal only when ALU_SEQ_CMP_EN is defined (see alu_sequencer).
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_MOVA = 3'd0,
    OP_MOVB = 3'd1,
    OP_ADD  = 3'd2,
    OP_SUB  = 3'd3,
    OP_NOR  = 3'd4,
    OP_CMP  = 3'd5
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OP,
    ST_FIX,
    ST_DONE
  } state_t;

  localparam logic [4:0] SEL_PASS_A = 5'b00000;
  localparam logic [4:0] SEL_SUB    = 5'b00110;
  localparam logic [4:0] SEL_PASS_B = 5'b11010;
  localparam logic [4:0] SEL_ADD    = 5'b01001;
  localparam logic [4:0] SEL_NOR    = 5'b10001;

  function automatic logic [4:0] op_sel(input op_t op);
    logic [4:0] sel;
    sel = SEL_PASS_A;
    case (op)
      OP_MOVB:        sel = SEL_PASS_B;
      OP_ADD:         sel = SEL_ADD;
      OP_SUB, OP_CMP: sel = SEL_SUB;
      OP_NOR:         sel = SEL_NOR;
      default:        sel = SEL_PASS_A;
    endcase
    return sel;
  endfunction

  // Operations whose nibbles chain a carry/borrow into the next nibble.
  function automatic logic op_arith(input op_t op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP);
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Request/response handshake bus plus the shared 4-bit ALU port of the sequencer.
// master = core side, slave = sequencer; the ALU result lines are driven by the external ALU.
interface alu_sequencer_if #(parameter int NIBBLES = 4);

  localparam int W = 4 * NIBBLES;

  logic         req_valid;
  logic         req_ready;
  logic [2:0]   req_op;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_carry;
  logic         rsp_zero;
  logic         rsp_err;

  logic [3:0]   alu_a;
  logic [3:0]   alu_b;
  logic [4:0]   alu_s;
  logic         alu_ncin;
  logic [3:0]   alu_f;
  logic         alu_cout;
  logic         alu_eq;

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready, alu_f, alu_cout, alu_eq,
    output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err,
           alu_a, alu_b, alu_s, alu_ncin
  );

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err
  );

endinterface

// File: rtl/alu_sequencer.sv
// Drives a wide operation through the shared 4-bit ALU one nibble per cycle, LSB first.
// Define ALU_SEQ_CMP_EN to make opcode 5 (CMP: borrow and zero only) legal.
module alu_sequencer #(
  parameter int NIBBLES = 4
) (
  input logic             clk,
  input logic             reset,
  alu_sequencer_if.slave  bus
);

  import alu_seq_pkg::*;

  localparam int W = 4 * NIBBLES;

  state_t       state;
  state_t       state_next;
  op_t          op_q;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic [W-1:0] result_q;
  logic [2:0]   idx;
  logic [4:0]   nib_base;
  logic [3:0]   part;
  logic         part_c;
  logic         carry_in;
  logic         zero_acc;
  logic         rsp_carry_q;
  logic         rsp_zero_q;
  logic         err_q;

  logic         req_fire;
  logic         req_legal;
  logic         last;
  logic         go_fix;
  logic         commit;
  logic         carry_next;
  logic         zero_next;

`ifdef ALU_SEQ_CMP_EN
  assign req_legal = (bus.req_op <= 3'd5);
`else
  assign req_legal = (bus.req_op <= 3'd4);
`endif

  assign req_fire   = (state == ST_IDLE) && bus.req_valid;
  assign nib_base   = {idx, 2'b00};
  assign last       = (idx == 3'(NIBBLES - 1));
  assign go_fix     = (state == ST_OP) && op_arith(op_q) && carry_in;
  assign commit     = ((state == ST_OP) && !go_fix) || (state == ST_FIX);
  assign carry_next = (state == ST_FIX) ? (part_c | bus.alu_cout)
                                        : (op_arith(op_q) & bus.alu_cout);
  assign zero_next  = zero_acc | ~bus.alu_eq;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (bus.req_valid) state_next = req_legal ? ST_OP : ST_DONE;
      ST_OP: begin
        if (go_fix)    state_next = ST_FIX;
        else if (last) state_next = ST_DONE;
      end
      ST_FIX:  state_next = last ? ST_DONE : ST_OP;
      ST_DONE: if (bus.rsp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // The FIX pass re-applies the pending carry/borrow to the partial nibble as +/-1.
  always_comb begin
    bus.req_ready  = (state == ST_IDLE);
    bus.rsp_valid  = (state == ST_DONE);
    bus.rsp_result = result_q;
    bus.rsp_carry  = rsp_carry_q;
    bus.rsp_zero   = rsp_zero_q;
    bus.rsp_err    = err_q;
    bus.alu_ncin   = 1'b1;
    bus.alu_a      = 4'h0;
    bus.alu_b      = 4'h0;
    bus.alu_s      = SEL_PASS_A;
    case (state)
      ST_OP: begin
        bus.alu_a = a_q[nib_base +: 4];
        bus.alu_b = b_q[nib_base +: 4];
        bus.alu_s = op_sel(op_q);
      end
      ST_FIX: begin
        bus.alu_a = part;
        bus.alu_b = 4'h1;
        bus.alu_s = (op_q == OP_ADD) ? SEL_ADD : SEL_SUB;
      end
      default: ;
    endcase
  end

  // CMP walks every nibble for the borrow and zero flags but never writes the result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q        <= OP_MOVA;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      idx         <= 3'd0;
      part        <= 4'h0;
      part_c      <= 1'b0;
      carry_in    <= 1'b0;
      zero_acc    <= 1'b0;
      rsp_carry_q <= 1'b0;
      rsp_zero_q  <= 1'b0;
      err_q       <= 1'b0;
    end else if (req_fire) begin
      op_q        <= op_t'(bus.req_op);
      a_q         <= bus.req_a;
      b_q         <= bus.req_b;
      result_q    <= '0;
      idx         <= 3'd0;
      carry_in    <= 1'b0;
      zero_acc    <= 1'b0;
      rsp_carry_q <= 1'b0;
      rsp_zero_q  <= ~req_legal;
      err_q       <= ~req_legal;
    end else if (go_fix) begin
      part   <= bus.alu_f;
      part_c <= bus.alu_cout;
    end else if (commit) begin
      if (op_q != OP_CMP) result_q[nib_base +: 4] <= bus.alu_f;
      zero_acc <= zero_next;
      carry_in <= carry_next;
      if (last) begin
        rsp_carry_q <= carry_next;
        rsp_zero_q  <= ~zero_next;
      end else begin
        idx <= idx + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Table-driven scoreboard bench for alu_sequencer with a behavioural 4-bit ALU.
// Expected CMP behaviour follows ALU_SEQ_CMP_EN, the same macro the design uses.
module tb_alu_sequencer;

  import alu_seq_pkg::*;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  typedef struct {
    string        name;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         carry;
    logic         zero;
    logic         err;
    int           lat;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic         carry;
    logic         zero;
    logic         err;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];
  vec_t vecs[11];

  alu_sequencer_if #(.NIBBLES(NIB)) bus();

  alu_sequencer #(.NIBBLES(NIB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // External ALU: SUB reports borrow (a < b) on cout.
  logic [4:0] alu_tmp;
  always_comb begin
    alu_tmp = 5'd0;
    case (bus.alu_s)
      SEL_PASS_A: alu_tmp = {1'b0, bus.alu_a};
      SEL_PASS_B: alu_tmp = {1'b0, bus.alu_b};
      SEL_ADD:    alu_tmp = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      SEL_SUB:    alu_tmp = {bus.alu_a < bus.alu_b, bus.alu_a - bus.alu_b};
      SEL_NOR:    alu_tmp = {1'b0, ~(bus.alu_a | bus.alu_b)};
      default:    alu_tmp = 5'd0;
    endcase
  end
  assign bus.alu_f    = alu_tmp[3:0];
  assign bus.alu_cout = alu_tmp[4];
  assign bus.alu_eq   = (alu_tmp[3:0] == 4'h0);

  function automatic vec_t mk(input string name, input logic [2:0] op,
                              input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] res, input logic carry,
                              input logic zero, input logic err, input int lat);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.res = res;
    v.carry = carry; v.zero = zero; v.err = err; v.lat = lat;
    return v;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Raises req_valid until the request is taken; returns #1 after the accept edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b, input bit push, input exp_t e,
                               output bit ok);
    int guard;
    guard = 0;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_valid = 1'b1;
    while (!bus.req_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    ok = bus.req_ready;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL req_accept_timeout: req_ready %0b, expected 1", bus.req_ready);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    if (push) sbq.push_back(e);
  endtask

  task automatic waitResponse(output int cyc, output bit ok);
    cyc = 0;
    while (!bus.rsp_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    ok = bus.rsp_valid;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL rsp_timeout: rsp_valid %0b, expected 1", bus.rsp_valid);
    end
  endtask

  task automatic checkOutput(input string name);
    exp_t e;
    if (sbq.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s_sb: response with empty scoreboard, expected entry", name);
    end else begin
      e = sbq.pop_front();
      checkVal({name, "_result"}, 32'(bus.rsp_result), 32'(e.res));
      checkVal({name, "_carry"},  32'(bus.rsp_carry),  32'(e.carry));
      checkVal({name, "_zero"},   32'(bus.rsp_zero),   32'(e.zero));
      checkVal({name, "_err"},    32'(bus.rsp_err),    32'(e.err));
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic runVec(input vec_t v);
    exp_t e;
    bit   ok;
    int   cyc;
    e.res = v.res; e.carry = v.carry; e.zero = v.zero; e.err = v.err;
    applyStimulus(v.op, v.a, v.b, 1'b1, e, ok);
    if (!ok) return;
    waitResponse(cyc, ok);
    if (!ok) begin
      void'(sbq.pop_front());
      return;
    end
    checkVal({v.name, "_latency"}, 32'(cyc), 32'(v.lat));
    checkOutput(v.name);
  endtask

  task automatic checkResetValues(input string name);
    checkVal({name, "_req_ready"}, 32'(bus.req_ready),  32'd1);
    checkVal({name, "_rsp_valid"}, 32'(bus.rsp_valid),  32'd0);
    checkVal({name, "_result"},    32'(bus.rsp_result), 32'd0);
    checkVal({name, "_carry"},     32'(bus.rsp_carry),  32'd0);
    checkVal({name, "_zero"},      32'(bus.rsp_zero),   32'd0);
    checkVal({name, "_err"},       32'(bus.rsp_err),    32'd0);
    checkVal({name, "_alu_a"},     32'(bus.alu_a),      32'd0);
    checkVal({name, "_alu_b"},     32'(bus.alu_b),      32'd0);
    checkVal({name, "_alu_s"},     32'(bus.alu_s),      32'd0);
  endtask

  initial begin
    exp_t e;
    bit   ok;
    int   cyc;
    int   seen;

    bus.req_valid = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;

    // Latency = clock edges from the accept edge until rsp_valid is seen.
    vecs[0]  = mk("add_00ff_1",   3'd2, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0, 6);
    vecs[1]  = mk("add_ffff_1",   3'd2, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 7);
    vecs[2]  = mk("sub_0_1",      3'd3, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0, 7);
    vecs[3]  = mk("sub_eq",       3'd3, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0, 4);
    vecs[4]  = mk("nor",          3'd4, 16'h00F0, 16'h0F00, 16'hF00F, 1'b0, 1'b0, 1'b0, 4);
    vecs[5]  = mk("add_nocarry",  3'd2, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b0, 4);
    vecs[6]  = mk("sub_8000_1",   3'd3, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b0, 7);
    vecs[7]  = mk("mova_zero",    3'd0, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 4);
    vecs[8]  = mk("illegal_op7",  3'd7, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1, 1'b1, 0);
    vecs[9]  = mk("illegal_op6",  3'd6, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b1, 0);
`ifdef ALU_SEQ_CMP_EN
    vecs[10] = mk("cmp_3_5",      3'd5, 16'h0003, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b0, 7);
`else
    vecs[10] = mk("cmp_3_5",      3'd5, 16'h0003, 16'h0005, 16'h0000, 1'b0, 1'b1, 1'b1, 0);
`endif

    repeat (2) @(posedge clk);
    #1;
    checkResetValues("por");
    reset = 1'b0;

    for (int i = 0; i < 11; i++) runVec(vecs[i]);

    // Back-pressure: response held while a competing request waits.
    e.res = 16'h3333; e.carry = 1'b0; e.zero = 1'b0; e.err = 1'b0;
    applyStimulus(3'd2, 16'h1111, 16'h2222, 1'b1, e, ok);
    if (ok) begin
      waitResponse(cyc, ok);
      if (ok) begin
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd3;
        bus.req_a     = 16'h0F0F;
        bus.req_b     = 16'h0101;
        for (int k = 0; k < 3; k++) begin
          @(posedge clk); #1;
          checkVal("bp_rsp_valid", 32'(bus.rsp_valid),  32'd1);
          checkVal("bp_req_ready", 32'(bus.req_ready),  32'd0);
          checkVal("bp_result",    32'(bus.rsp_result), 32'h3333);
        end
        bus.req_valid = 1'b0;
        checkOutput("bp");
        checkVal("bp_idle_req_ready", 32'(bus.req_ready), 32'd1);
        checkVal("bp_idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      end else begin
        void'(sbq.pop_front());
      end
    end

    // Reset one cycle after accepting an ADD: the operation must vanish.
    applyStimulus(3'd2, 16'h00FF, 16'h0001, 1'b0, e, ok);
    if (ok) begin
      reset = 1'b1;
      #1;
      checkResetValues("midop_rst");
      @(posedge clk); #1;
      reset = 1'b0;
      seen = 0;
      for (int k = 0; k < 10; k++) begin
        @(posedge clk); #1;
        if (bus.rsp_valid) seen++;
      end
      checkVal("midop_no_rsp", 32'(seen), 32'd0);
    end
    runVec(mk("movb_after_rst", 3'd1, 16'h1234, 16'hABCD, 16'hABCD, 1'b0, 1'b0, 1'b0, 4));

    checkVal("sb_empty", 32'(sbq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-nibble operation sequencer for the 4-bit ALU. It accepts one wide operation from the core over a valid/ready request port. It then drives the ALU one nibble per cycle, LSB first, and chains carry/borrow between nibbles with extra ALU correction passes. It returns the wide result, the final carry and a zero flag over a valid/ready response port. It sits between the core control unit and the single shared ALU instance, which the parent instantiates.

## Interface
- NIBBLES, 4: operand width in nibbles (W = 4*NIBBLES); legal range 2..8.
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid / req_ready  in / out  1 / 1  request handshake; transfer when both are high at a clk edge.
- req_op  in  3  0 MOVA, 1 MOVB, 2 ADD, 3 SUB, 4 NOR, 5 CMP, 6–7 illegal.
- req_a, req_b  in  W / W  operands.
- rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
- rsp_result  out  W  result (CMP: 0).
- rsp_carry  out  1  carry out of the top nibble (ADD), or borrow (SUB/CMP); 0 otherwise.
- rsp_zero  out  1  1 when the full W-bit computed value is zero (CMP: the difference).
- rsp_err  out  1  illegal op.
- alu_a, alu_b  out  4 / 4  ALU operands.
- alu_s  out  5  ALU select.
- alu_ncin  out  1  tied 1.
- alu_cout, alu_eq  in  1 / 1  ALU flags; eq = result nibble is zero.

## Operation
- States: IDLE, OP, FIX, DONE. req_ready = (state==IDLE). rsp_valid = (state==DONE).
- IDLE + handshake:
  - Latch op, a, b.
  - Clear result, carry and zero_acc; set idx=0.
  - Legal op → OP. Illegal op → DONE with err=1, result 0, carry 0, zero 1.
- OP, nibble idx:
  - alu_a = a[idx], alu_b = b[idx].
  - alu_s: MOVA 00000, MOVB 11010, ADD 01001, SUB/CMP 00110, NOR 10001.
  - Edge: part = ALU result and c1 = alu_cout.
  - If ADD/SUB/CMP and carry_in==1 → FIX.
  - Otherwise commit the nibble, set carry_in = c1 (0 for MOVA/MOVB/NOR), and advance.
- FIX, nibble idx:
  - alu_a = part, alu_b = 4'h1, alu_s = ADD (for ADD) or SUB (for SUB/CMP).
  - Edge: commit the ALU result, set carry_in = c1 | alu_cout, and advance.
- Commit:
  - result[idx] = nibble (not written for CMP).
  - zero_acc |= ~alu_eq.
- Advance: idx==NIBBLES-1 → DONE with carry = carry_in, zero = ~zero_acc. Otherwise idx+1 → OP.
- DONE: outputs held stable until rsp_ready; on handshake → IDLE. A new request is accepted only in IDLE.
- Width rules: carry_in of nibble 0 is 0. All arithmetic is modulo 2^W. Borrow is set when a < b (unsigned).
- In IDLE/DONE: alu_a = alu_b = 0, alu_s = 00000.

## Timing
- One ALU pass per cycle; the ALU is combinational and is sampled at the end of each OP/FIX cycle.
- rsp_valid rises NIBBLES + F cycles after the request edge, where F = number of FIX passes (0..NIBBLES-1).
- Back-to-back: next request accepted at the earliest on the edge after the response handshake (1 IDLE cycle).
- Reset values, also applied asynchronously mid-operation:
  - State IDLE, req_ready 1, rsp_valid 0.
  - rsp_result 0, rsp_carry 0, rsp_zero 0, rsp_err 0.
  - alu_a 0, alu_b 0, alu_s 00000.
  - An in-flight operation is discarded with no response.

## Configuration
- ALU_SEQ_CMP_EN defined: op 5 (CMP) is legal. It runs as SUB, leaves rsp_result at 0, and reports borrow and zero only.
- ALU_SEQ_CMP_EN undefined: op 5 is illegal (rsp_err=1 path, single IDLE→DONE transition).

## Structure
- Package alu_seq_pkg contains:
  - Op enum (3 bits) and state enum.
  - ALU select constants: SEL_PASS_A 5'b00000, SEL_SUB 5'b00110, SEL_PASS_B 5'b11010, SEL_ADD 5'b01001, SEL_NOR 5'b10001.
- No sub-module. The nibble select is an indexed part-select; the ALU stays external.

## Test plan
- ADD 0x00FF+0x0001 → result 0x0100, carry 0, zero 0, err 0. rsp_valid 6 cycles after accept (FIX on nibbles 1 and 2).
- ADD 0xFFFF+0x0001 → 0x0000, carry 1, zero 1; SUB 0x0000−0x0001 → 0xFFFF, carry 1, zero 0.
- SUB 0x1234−0x1234 → 0x0000, carry 0, zero 1, 4 cycles. NOR 0x00F0,0x0F00 → 0xF00F, carry 0.
- Back-pressure: hold rsp_ready=0 for 3 cycles after rsp_valid → outputs stable, req_ready 0, concurrent req_valid not accepted. Handshake → IDLE next cycle.
- Assert reset in the cycle after accepting ADD → immediate reset values, no response. The following MOVB 0xABCD → 0xABCD, carry 0.
- op 7 → err 1, result 0, zero 1, 1 cycle. op 5 on 0x0003,0x0005: with ALU_SEQ_CMP_EN → result 0, carry 1, zero 0; without it → err 1.
